// File: rtl/systolic_mm_nxn.sv
// N x N output-stationary systolic matrix multiplier, C = A*B, signed operands.
// Define SYSTOLIC_SAT_EN for saturating accumulation with a sticky ovf flag; otherwise results wrap.
module systolic_mm_nxn #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*DATA_WIDTH-1:0]   a_col,
  input  logic [N*DATA_WIDTH-1:0]   b_row,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N*ACC_WIDTH-1:0]    out_row,
  output logic [$clog2(N)-1:0]      out_idx,
  output logic                      busy,
  output logic                      ovf
);
  localparam int KW = $clog2(N);
  localparam int TW = $clog2(3*N-1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_COMP  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // Returns {clamp, next_acc}.
  function automatic logic [ACC_WIDTH:0] acc_add(input logic signed [ACC_WIDTH-1:0] acc,
                                                 input logic signed [2*DATA_WIDTH-1:0] p);
`ifdef SYSTOLIC_SAT_EN
    logic signed [ACC_WIDTH:0] wide;
    logic signed [ACC_WIDTH:0] hi;
    logic signed [ACC_WIDTH:0] lo;
    hi   = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    lo   = {2'b11, {(ACC_WIDTH-1){1'b0}}};
    wide = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(p);
    if (wide > hi)      acc_add = {1'b1, hi[ACC_WIDTH-1:0]};
    else if (wide < lo) acc_add = {1'b1, lo[ACC_WIDTH-1:0]};
    else                acc_add = {1'b0, wide[ACC_WIDTH-1:0]};
`else
    logic signed [ACC_WIDTH-1:0] sum;
    sum     = acc + ACC_WIDTH'(p);
    acc_add = {1'b0, sum};
`endif
  endfunction

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, r_q;
  logic [TW-1:0] t_q;
  logic          ovf_q;

  logic signed [DATA_WIDTH-1:0] a_op_q [N][N];
  logic signed [DATA_WIDTH-1:0] b_op_q [N][N];
  logic signed [DATA_WIDTH-1:0] a_edge [N];
  logic signed [DATA_WIDTH-1:0] b_edge [N];
  logic signed [DATA_WIDTH-1:0] a_hop  [N][N-1];
  logic signed [DATA_WIDTH-1:0] b_hop  [N-1][N];
  logic signed [ACC_WIDTH-1:0]  acc_w  [N][N];
  logic [N*N-1:0]               clamp_v;

  logic accept_in, last_in, computing, comp_done, accept_out, last_out;

  assign in_ready   = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign out_valid  = (state_q == S_DRAIN);
  assign busy       = (state_q != S_IDLE);
  assign out_idx    = r_q;
  assign ovf        = ovf_q;
  assign accept_in  = in_valid & in_ready;
  assign last_in    = accept_in & (k_q == KW'(N-1));
  assign computing  = (state_q == S_COMP);
  assign comp_done  = computing & (t_q == TW'(3*N-3));
  assign accept_out = out_valid & out_ready;
  assign last_out   = accept_out & (r_q == KW'(N-1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_in)  state_d = S_LOAD;
      S_LOAD:  if (last_in)    state_d = S_COMP;
      S_COMP:  if (comp_done)  state_d = S_DRAIN;
      default: if (last_out)   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      t_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_in)  k_q <= last_in ? '0 : k_q + 1'b1;
      t_q <= (computing && !comp_done) ? t_q + 1'b1 : '0;
      if (accept_out) r_q <= last_out ? '0 : r_q + 1'b1;
      if (last_in)         ovf_q <= 1'b0;
      else if (|clamp_v)   ovf_q <= 1'b1;
    end
  end

  // Operand capture: beat k carries column k of A and row k of B.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_op_q[i][j] <= '0;
          b_op_q[i][j] <= '0;
        end
    end else if (accept_in) begin
      for (int i = 0; i < N; i++) begin
        a_op_q[i][k_q] <= a_col[i*DATA_WIDTH +: DATA_WIDTH];
        b_op_q[k_q][i] <= b_row[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Skewed edge feed: row/column n lags by n cycles, zero outside its window.
  always_comb begin
    int d;
    d = 0;
    for (int n = 0; n < N; n++) begin
      a_edge[n] = '0;
      b_edge[n] = '0;
      d = int'(t_q) - n;
      if (d >= 0 && d < N) begin
        a_edge[n] = a_op_q[n][d[KW-1:0]];
        b_edge[n] = b_op_q[d[KW-1:0]][n];
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic signed [DATA_WIDTH-1:0]   a_in, b_in;
      logic signed [2*DATA_WIDTH-1:0] prod;
      logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
      logic                           clamp;

      if (gj == 0) begin : g_aedge
        assign a_in = a_edge[gi];
      end else begin : g_ain
        assign a_in = a_hop[gi][gj-1];
      end
      if (gi == 0) begin : g_bedge
        assign b_in = b_edge[gj];
      end else begin : g_bin
        assign b_in = b_hop[gi-1][gj];
      end

      assign prod           = a_in * b_in;
      assign {clamp, acc_d} = acc_add(acc_q, prod);
      assign acc_w[gi][gj]  = acc_q;
      assign clamp_v[gi*N+gj] = clamp & computing;

      always_ff @(posedge clk) begin
        if (rst || last_in) acc_q <= '0;
        else if (computing) acc_q <= acc_d;
      end

      if (gj < N-1) begin : g_ahop
        logic signed [DATA_WIDTH-1:0] a_q;
        always_ff @(posedge clk) begin
          if (rst || last_in) a_q <= '0;
          else if (computing) a_q <= a_in;
        end
        assign a_hop[gi][gj] = a_q;
      end
      if (gi < N-1) begin : g_bhop
        logic signed [DATA_WIDTH-1:0] b_q;
        always_ff @(posedge clk) begin
          if (rst || last_in) b_q <= '0;
          else if (computing) b_q <= b_in;
        end
        assign b_hop[gi][gj] = b_q;
      end
    end
  end

  always_comb begin
    out_row = '0;
    if (state_q == S_DRAIN)
      for (int j = 0; j < N; j++)
        out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc_w[r_q][j];
  end

endmodule

// File: tb/tb_systolic_mm_nxn.sv
// Directed bench for systolic_mm_nxn at N=4, ACC_WIDTH=16; follows SYSTOLIC_SAT_EN for the extremes case.
module tb_systolic_mm_nxn;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int LAT = 3*N-2;
`ifdef SYSTOLIC_SAT_EN
  localparam int EXT_VAL = 32767;
  localparam int EXT_OVF = 1;
`else
  localparam int EXT_VAL = -16384;
  localparam int EXT_OVF = 0;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, busy, ovf;
  logic [N*DW-1:0] a_col, b_row;
  logic [N*AW-1:0] out_row;
  logic [$clog2(N)-1:0] out_idx;

  int n_chk = 0;
  int n_err = 0;
  int A[N][N], B[N][N], C[N][N];
  int lat;

  always #5 clk = ~clk;

  systolic_mm_nxn #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_idx(out_idx),
    .busy(busy), .ovf(ovf)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint elem(input int j);
    logic signed [AW-1:0] v;
    v = out_row[j*AW +: AW];
    return longint'(v);
  endfunction

  task automatic model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        C[i][j] = 0;
        for (int k = 0; k < N; k++) C[i][j] += A[i][k] * B[k][j];
      end
  endtask

  task automatic load(input bit gap);
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = DW'(A[i][k]);
        b_row[i*DW +: DW] = DW'(B[k][i]);
      end
      in_valid = 1'b1;
      check("in_ready_load", in_ready, 1);
      step();
      in_valid = 1'b0;
      if (gap && k != N-1) step();
    end
    check("in_ready_after_load", in_ready, 0);
    check("busy_after_load", busy, 1);
  endtask

  task automatic wait_result(input bit junk, output int edges);
    edges = 0;
    while (!out_valid && edges < 100) begin
      if (junk) begin
        in_valid = 1'b1;
        a_col = $urandom;
        b_row = $urandom;
        check("in_ready_compute", in_ready, 0);
      end
      step();
      edges++;
    end
    in_valid = 1'b0;
    check("out_valid_rise", out_valid, 1);
  endtask

  task automatic drain(input int stall, input int exp_ovf);
    check("ovf_drain", ovf, exp_ovf);
    for (int r = 0; r < N; r++) begin
      for (int s = 0; s < stall; s++) begin
        check("stall_valid", out_valid, 1);
        check("stall_in_ready", in_ready, 0);
        check("stall_idx", out_idx, r);
        for (int j = 0; j < N; j++) check($sformatf("stall_C[%0d][%0d]", r, j), elem(j), C[r][j]);
        step();
      end
      check("row_idx", out_idx, r);
      for (int j = 0; j < N; j++) check($sformatf("C[%0d][%0d]", r, j), elem(j), C[r][j]);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    check("in_ready_after_drain", in_ready, 1);
    check("out_valid_after_drain", out_valid, 0);
    check("busy_after_drain", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_col = '0; b_row = '0;
    repeat (3) step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_row", longint'(out_row), 0);
    check("rst_out_idx", out_idx, 0);
    rst = 1'b0;
    step();

    // Identity: C equals B.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = (i == j) ? 1 : 0;
        B[i][j] = 4*i + j + 1;
        C[i][j] = B[i][j];
      end
    load(1'b0);
    wait_result(1'b0, lat);
    check("latency_identity", lat, LAT);
    drain(0, 0);

    // Signed extremes in the top-left 3x3 block: 3 * 16384 per element.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = (i < 3 && j < 3) ? -128 : 0;
        B[i][j] = (i < 3 && j < 3) ? -128 : 0;
        C[i][j] = (i < 3 && j < 3) ? EXT_VAL : 0;
      end
    load(1'b0);
    wait_result(1'b0, lat);
    check("latency_extremes", lat, LAT);
    drain(0, EXT_OVF);
    check("ovf_idle_hold", ovf, EXT_OVF);

    // Load gaps, junk in_valid during compute, 5-cycle stalls per row.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = (i*4 + j) - 7;
        B[i][j] = 3 - (i + 2*j);
      end
    model();
    load(1'b1);
    check("ovf_cleared_by_load", ovf, 0);
    wait_result(1'b1, lat);
    check("latency_gapped", lat, LAT);
    drain(5, 0);

    // Reset at COMPUTE t=2, then a fresh identity job.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = 5 - i - j;
        B[i][j] = i * j + 1;
      end
    load(1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = (i == j) ? 1 : 0;
        B[i][j] = 10*i - j;
        C[i][j] = B[i][j];
      end
    load(1'b0);
    wait_result(1'b0, lat);
    check("latency_after_rst", lat, LAT);
    drain(0, 0);

    // Back-to-back jobs, second load the cycle after the last row is taken.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = i + j + 1;
        B[i][j] = j - i;
      end
    model();
    load(1'b0);
    wait_result(1'b0, lat);
    drain(0, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = 2 - i*j;
        B[i][j] = i*j - 3;
      end
    model();
    load(1'b0);
    wait_result(1'b0, lat);
    check("latency_b2b", lat, LAT);
    drain(0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
